// File: rtl/union_field_packer.sv
// Field-to-word packer: fills a packed union field by field and emits it as a whole word.
// Optional macro UNION_PACK_MSB_FIRST_EN places the first field in the MSBs instead of the LSBs.
module union_field_packer #(
  parameter int FIELD_W    = 4,
  parameter int NUM_FIELDS = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FIELD_W-1:0]                in_field,
  input  logic                              in_flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [FIELD_W*NUM_FIELDS-1:0]     out_word,
  output logic [$clog2(NUM_FIELDS+1)-1:0]   out_count
);

  localparam int WORD_W = FIELD_W * NUM_FIELDS;
  localparam int IDX_W  = $clog2(NUM_FIELDS);
  localparam int CNT_W  = $clog2(NUM_FIELDS + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

  // The two views of the same storage: flat word and per-field array.
  typedef union packed {
    logic [WORD_W-1:0]                    word;
    logic [NUM_FIELDS-1:0][FIELD_W-1:0]   fields;
  } acc_t;

  acc_t             acc;
  acc_t             merged;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] slot;
  logic             close;
  logic             accept;
  logic             out_fire;

  // Physical field position for the logical fill index.
`ifdef UNION_PACK_MSB_FIRST_EN
  assign slot = LAST_IDX - idx;
`else
  assign slot = idx;
`endif

  assign close    = (idx == LAST_IDX) || in_flush;
  assign in_ready = !(close && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Unwritten fields are already zero because acc is cleared after every close.
  always_comb begin
    // NOTE: assign the whole variable first so no path leaves it unassigned (no latch).
    merged              = acc;
    merged.fields[slot] = in_field;
  end

  // Fill side: accumulator and field index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every state register, including the wide accumulator, gets a reset value.
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      if (close) begin
        acc <= '0;
        idx <= '0;
      end else begin
        acc <= merged;
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Output side: a new close overrides a same-edge handshake, keeping out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_count <= '0;
    end else if (accept && close) begin
      out_valid <= 1'b1;
      out_word  <= merged.word;
      out_count <= CNT_W'(idx) + CNT_W'(1);
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/union_field_packer.md
# union_field_packer

Sequential field-to-word packer for packed-union regression designs. Accepts one union field per valid/ready handshake, fills a packed union whose two views are a flat `word` and an array `fields[NUM_FIELDS]`, and presents the completed union as a whole word on a second valid/ready interface. It is the write-by-field, read-by-word direction of union access: fields go in and the full union comes out. It is double-buffered: one union is filled while the previous one waits at the output.

## Interface
Parameters:
- `FIELD_W`, default 4: width of one union field.
- `NUM_FIELDS`, default 4: number of fields in the union. Must be ≥2.
- `WORD_W` is derived as `FIELD_W*NUM_FIELDS`. It is a localparam, not overridable.

Ports:
- `clk`  in  1  single clock; all logic samples on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a field is offered.
- `in_ready`  out  1  the packer can accept a field this cycle.
- `in_field`  in  FIELD_W  field value.
- `in_flush`  in  1  qualified by `in_valid`. Accept `in_field` as the final field and close the word early.
- `out_valid`  out  1  a completed union is held on `out_word`.
- `out_ready`  in  1  downstream accepts `out_word`.
- `out_word`  out  WORD_W  union read through its `word` view.
- `out_count`  out  $clog2(NUM_FIELDS+1)  number of fields actually written into `out_word`.

## Operation
- Internal state:
  - Fill register `acc`, which is a packed union.
  - Field index `idx`, range 0..NUM_FIELDS-1.
  - Output register holding `out_word`, `out_count` and `out_valid`.
- Accept event is `in_valid && in_ready`. It writes `acc.fields[idx] = in_field`.
- Word-close condition: `idx == NUM_FIELDS-1`, or `in_flush` is set.
- On the accepting edge of a close:
  - `out_word` = `acc`, with the new field merged in and every unwritten field forced to 0.
  - `out_count` = `idx+1`.
  - `out_valid` = 1.
  - `acc` is cleared to 0 and `idx` returns to 0.
- An accept without a close increments `idx`.
- Output handshake: `out_valid && out_ready` clears `out_valid` unless a new close happens on the same edge. In that case the new word replaces the old one and `out_valid` stays 1.
- `in_ready` = NOT (a close would occur AND `out_valid` AND NOT `out_ready`):
  - It drops only when the closing field cannot be transferred.
  - Non-closing fields are always accepted.
  - `in_ready` depends combinationally on `out_ready`, `in_flush` and `idx`. It has no dependence on `in_valid`.
- `in_flush` with `in_valid` low is ignored.
- A flush when `idx == 0` emits a one-field word.
- `out_word`, `out_count` and `out_valid` are stable while `out_valid && !out_ready`.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `out_valid` = 0, `out_word` = 0, `out_count` = 0.
  - `acc` = 0, `idx` = 0.
  - `in_ready` = 1.
- Latency: `out_valid` rises the cycle after the edge that accepts the closing field.
- Throughput: one field per cycle sustained, and one word every NUM_FIELDS cycles with `out_ready` held high. There are no bubbles.
- Back-to-back: closing field accepted on the same edge as an output handshake gives a new word with `out_valid` continuously 1.
- Reset mid-fill discards the partial `acc` and any pending output. No word is emitted after reset releases.
- Reset deassertion is used as-is. No internal synchronizer.

## Configuration
- Macro: `UNION_PACK_MSB_FIRST_EN`.
- Undefined (default): field k fills `fields[k]`, i.e. bits [k*FIELD_W +: FIELD_W]. The first field lands in the LSBs.
- Defined: field k fills `fields[NUM_FIELDS-1-k]`. The first field lands in the MSBs.
  - A flushed word keeps its written fields at the top and zeros below.
  - `out_count` semantics are unchanged.

## Test plan
All scenarios use FIELD_W=4, NUM_FIELDS=4.

1. Fields 0xA, 0x5, 0x3, 0xC on consecutive cycles, `out_ready`=1 → one cycle after the 4th accept: `out_word`=0xC35A, `out_count`=4, `out_valid` for 1 cycle. With `UNION_PACK_MSB_FIRST_EN`: 0xA53C.
2. Fields 0xA then 0x5 with `in_flush` → `out_word`=0x005A, `out_count`=2. The next word starts at field 0. With the macro: 0xA500.
3. Hold `out_ready`=0 after word 0x4321 completes, then send 3 more fields 0x1, 0x2, 0x3 → all accepted. With the 4th field (0x4) presented, `in_ready`=0 and `out_word` stays 0x4321. Raise `out_ready` → same-edge accept; `out_word` becomes 0x4321 again from the new fill and `out_valid` never drops.
4. 12 fields streamed continuously with `out_ready`=1 → three words, each one cycle after its closing field, with no `in_ready` gaps.
5. Assert `rst_n`=0 after 2 fields of a word and with an unaccepted word pending → all outputs zero immediately and `in_ready`=1. After release, fields 0xF×4 produce exactly one word, 0xFFFF.
6. `in_flush`=1 with `in_valid`=0 for several cycles → no state change and no output.
